// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared state encoding and widths for the video line fetch engine
package video_pkg;

  localparam int ADDR_W  = 24;
  localparam int WORDS_W = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with synchronous flush
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/video_line_fetch.sv
// rtl/video_line_fetch.sv - scanline burst fetcher feeding a pixel FIFO; VIDEO_LINE_FETCH_UNDERRUN_EN adds a sticky underrun flag
module video_line_fetch
  import video_pkg::*;
#(
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               line_start_i,
  input  logic [ADDR_W-1:0]  line_base_i,
  input  logic [WORDS_W-1:0] line_words_i,
  output logic               line_done_o,
  output logic               busy_o,
  output logic               sdram_rd_o,
  output logic [ADDR_W-1:0]  sdram_addr_x16_o,
  input  logic               sdram_rdy_i,
  input  logic               sdram_resp_valid_i,
  input  logic [15:0]        sdram_rdata_i,
  output logic               sdram_ack_o,
  input  logic               pix_rd_i,
  output logic [15:0]        pix_data_o,
  output logic               pix_empty_o
`ifdef VIDEO_LINE_FETCH_UNDERRUN_EN
  ,
  output logic               underrun_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int SW = CW + 2;
  localparam logic [WORDS_W-1:0] BURST_MASK = WORDS_W'(BURST_LEN - 1);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, pend_base_q, pend_base_d;
  logic [WORDS_W-1:0] remain_q, remain_d, pend_words_q, pend_words_d;
  logic               busy_q, busy_d, done_q, done_d, pend_q, pend_d;
  logic [BW-1:0]      beat_q, beat_d;

  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty, fifo_flush, push_en, launch;
  logic [BW-1:0]      outstanding;
  logic [SW-1:0]      committed;
  logic               credit_ok;
  logic [ADDR_W-1:0]  start_base;
  logic [WORDS_W-1:0] start_words, next_remain;

  // Words already promised to the FIFO: occupancy plus beats still owed by the in-flight burst.
  always_comb begin
    outstanding = '0;
    if (state_q == REQ || state_q == DATA) outstanding = BW'(BURST_LEN) - beat_q;
    committed = SW'(fifo_count) + SW'(outstanding) + SW'(BURST_LEN);
    credit_ok = !fifo_full && (committed <= SW'(FIFO_DEPTH));
  end

  assign push_en = (state_q == DATA) && sdram_resp_valid_i && !pend_q && !line_start_i;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pend_d       = pend_q;
    pend_base_d  = pend_base_q;
    pend_words_d = pend_words_q;
    beat_d       = beat_q;
    fifo_flush   = 1'b0;
    launch       = 1'b0;
    start_base   = line_start_i ? line_base_i : pend_base_q;
    start_words  = (line_start_i ? line_words_i : pend_words_q) & ~BURST_MASK;
    next_remain  = remain_q - WORDS_W'(BURST_LEN);

    case (state_q)
      IDLE: begin
        if (line_start_i) launch = 1'b1;
        else if (busy_q && remain_q != '0 && credit_ok) state_d = REQ;
      end
      REQ: begin
        if (sdram_rdy_i) state_d = DATA;
      end
      DATA: begin
        if (sdram_resp_valid_i) begin
          if (beat_q == BW'(BURST_LEN - 1)) begin
            beat_d  = '0;
            state_d = ACK;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ACK: begin
        if (pend_q || line_start_i) begin
          launch = 1'b1;
        end else begin
          addr_d   = addr_q + ADDR_W'(BURST_LEN);
          remain_d = next_remain;
          if (next_remain == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = credit_ok ? REQ : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A start arriving mid-burst waits until the burst has been released.
    if (line_start_i && (state_q == REQ || state_q == DATA)) begin
      pend_d       = 1'b1;
      pend_base_d  = line_base_i;
      pend_words_d = line_words_i;
    end

    if (launch) begin
      fifo_flush = 1'b1;
      pend_d     = 1'b0;
      addr_d     = start_base;
      remain_d   = start_words;
      busy_d     = (start_words != '0);
      done_d     = (start_words == '0);
      state_d    = (start_words != '0) ? REQ : IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_base_q  <= '0;
      pend_words_q <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pend_q       <= pend_d;
      pend_base_q  <= pend_base_d;
      pend_words_q <= pend_words_d;
      beat_q       <= beat_d;
    end
  end

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (fifo_flush),
    .push_i  (push_en),
    .data_i  (sdram_rdata_i),
    .pop_i   (pix_rd_i),
    .data_o  (pix_data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign sdram_rd_o       = (state_q == REQ);
  assign sdram_ack_o      = (state_q == ACK);
  assign sdram_addr_x16_o = addr_q;
  assign busy_o           = busy_q;
  assign line_done_o      = done_q;
  assign pix_empty_o      = fifo_empty;

`ifdef VIDEO_LINE_FETCH_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  underrun_q <= 1'b0;
    else if (line_start_i)                        underrun_q <= 1'b0;
    else if (pix_rd_i && fifo_empty && busy_q)    underrun_q <= 1'b1;
  end

  assign underrun_o = underrun_q;
`endif

endmodule

// File: tb/tb_video_line_fetch.sv
// tb/tb_video_line_fetch.sv - scoreboard bench for video_line_fetch with an SDRAM responder model
module tb_video_line_fetch;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start_i;
  logic [23:0] line_base_i;
  logic [10:0] line_words_i;
  logic        line_done_o, busy_o, sdram_rd_o, sdram_ack_o;
  logic [23:0] sdram_addr_x16_o;
  logic        sdram_rdy_i, sdram_resp_valid_i;
  logic [15:0] sdram_rdata_i;
  logic        pix_rd_i;
  logic [15:0] pix_data_o;
  logic        pix_empty_o;
`ifdef VIDEO_LINE_FETCH_UNDERRUN_EN
  logic        underrun_o;
`endif

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  logic        got_valid;
  logic [23:0] exp_addr[$];
  logic [15:0] exp_pix[$];

  always #5 clk = ~clk;

  video_line_fetch #(.BURST_LEN(BL), .FIFO_DEPTH(32)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .line_start_i       (line_start_i),
    .line_base_i        (line_base_i),
    .line_words_i       (line_words_i),
    .line_done_o        (line_done_o),
    .busy_o             (busy_o),
    .sdram_rd_o         (sdram_rd_o),
    .sdram_addr_x16_o   (sdram_addr_x16_o),
    .sdram_rdy_i        (sdram_rdy_i),
    .sdram_resp_valid_i (sdram_resp_valid_i),
    .sdram_rdata_i      (sdram_rdata_i),
    .sdram_ack_o        (sdram_ack_o),
    .pix_rd_i           (pix_rd_i),
    .pix_data_o         (pix_data_o),
    .pix_empty_o        (pix_empty_o)
`ifdef VIDEO_LINE_FETCH_UNDERRUN_EN
    ,
    .underrun_o         (underrun_o)
`endif
  );

  function automatic logic [15:0] wdata(input logic [23:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_line(input logic [23:0] base, input logic [10:0] words);
    line_base_i  = base;
    line_words_i = words;
    line_start_i = 1'b1;
    tick(1);
    line_start_i = 1'b0;
  endtask

  task automatic expect_line(input logic [23:0] base, input int words, input bit with_pix);
    int n;
    n = words & ~(BL - 1);
    for (int b = 0; b < n / BL; b++) exp_addr.push_back(base + 24'(b * BL));
    if (with_pix)
      for (int w = 0; w < n; w++) exp_pix.push_back(wdata(base + 24'(w)));
  endtask

  task automatic pop_words(input int n, input int bound);
    int got;
    got = 0;
    for (int i = 0; i < bound && got < n; i++) begin
      pix_rd_i = !pix_empty_o;
      if (!pix_empty_o) got++;
      tick(1);
    end
    pix_rd_i = 1'b0;
    check("pop_count", got, n);
  endtask

  task automatic wait_done(input int target, input int bound);
    for (int i = 0; i < bound && done_cnt < target; i++) tick(1);
    check("done_wait", done_cnt, target);
  endtask

  task automatic wait_req(input int target, input int bound);
    for (int i = 0; i < bound && req_cnt < target; i++) tick(1);
    check("req_wait", req_cnt, target);
  endtask

  task automatic wait_data(input int bound);
    got_valid = 1'b0;
    for (int i = 0; i < bound && !got_valid; i++) begin
      @(posedge clk);
      #3;
      got_valid = sdram_resp_valid_i;
    end
  endtask

  initial begin : responder
    logic [23:0] a;
    sdram_rdy_i        = 1'b0;
    sdram_resp_valid_i = 1'b0;
    sdram_rdata_i      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sdram_rd_o) begin
        a = sdram_addr_x16_o;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        sdram_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        sdram_rdy_i = 1'b0;
        for (int i = 0; i < BL; i++) begin
          if (!rst_n) break;
          sdram_resp_valid_i = 1'b1;
          sdram_rdata_i      = wdata(a + 24'(i));
          @(posedge clk);
          #1;
        end
        sdram_resp_valid_i = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sdram_rd_o && sdram_rdy_i) begin
          req_cnt++;
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected addr=%06h", sdram_addr_x16_o);
          end else begin
            check("req_addr", sdram_addr_x16_o, exp_addr.pop_front());
          end
        end
        if (sdram_ack_o) begin
          ack_cnt++;
          check("ack_rd_low", sdram_rd_o, 1'b0);
        end
        if (line_done_o) done_cnt++;
        if (pix_rd_i && !pix_empty_o) begin
          if (exp_pix.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pix_unexpected data=%04h", pix_data_o);
          end else begin
            check("pix_data", pix_data_o, exp_pix.pop_front());
          end
        end
        if (dut.u_fifo.push_i && dut.u_fifo.full_o) begin
          errors++;
          $display("FAIL push_full actual=push expected=no_push");
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n        = 1'b0;
    line_start_i = 1'b0;
    line_base_i  = '0;
    line_words_i = '0;
    pix_rd_i     = 1'b0;
    tick(3);
    check("rst_rd", sdram_rd_o, 1'b0);
    check("rst_ack", sdram_ack_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", line_done_o, 1'b0);
    check("rst_empty", pix_empty_o, 1'b1);
`ifdef VIDEO_LINE_FETCH_UNDERRUN_EN
    check("rst_underrun", underrun_o, 1'b0);
`endif
    rst_n = 1'b1;
    tick(2);

    // Single line of two bursts
    expect_line(24'h000100, 8, 1'b1);
    start_line(24'h000100, 11'd8);
    check("t1_rd_first", sdram_rd_o, 1'b1);
    check("t1_busy", busy_o, 1'b1);
    wait_done(1, 200);
    check("t1_busy_low", busy_o, 1'b0);
    tick(3);
    check("t1_req", req_cnt, 2);
    check("t1_ack", ack_cnt, 2);
    check("t1_done_once", done_cnt, 1);
    pop_words(8, 40);
    check("t1_empty", pix_empty_o, 1'b1);
    pix_rd_i = 1'b1;
    tick(1);
    pix_rd_i = 1'b0;
    check("t1_empty_pop", pix_empty_o, 1'b1);

    // Credit stall with no pixel pops
    expect_line(24'h002000, 64, 1'b1);
    start_line(24'h002000, 11'd64);
    wait_req(10, 200);
    tick(40);
    check("t2_req_stall", req_cnt, 10);
    check("t2_rd_low", sdram_rd_o, 1'b0);
    check("t2_busy", busy_o, 1'b1);
    pop_words(4, 10);
    wait_req(11, 30);
    pop_words(60, 1500);
    wait_done(2, 300);
    check("t2_req_total", req_cnt, 18);

    // Abort during the data phase of burst 2
    exp_addr.push_back(24'h003000);
    exp_addr.push_back(24'h003004);
    expect_line(24'h004000, 8, 1'b1);
    start_line(24'h003000, 11'd16);
    wait_req(20, 60);
    wait_data(10);
    check("t3_in_data", got_valid, 1'b1);
    line_base_i  = 24'h004000;
    line_words_i = 11'd8;
    line_start_i = 1'b1;
    @(posedge clk);
    #1;
    line_start_i = 1'b0;
    wait_done(3, 200);
    tick(3);
    check("t3_req", req_cnt, 22);
    check("t3_ack", ack_cnt, 22);
    check("t3_done_once", done_cnt, 3);
    pop_words(8, 40);
    check("t3_empty", pix_empty_o, 1'b1);

    // Degenerate lengths
    start_line(24'h005000, 11'd3);
    check("t4_done_pulse", line_done_o, 1'b1);
    check("t4_busy", busy_o, 1'b0);
    check("t4_rd", sdram_rd_o, 1'b0);
    tick(1);
    check("t4_done_single", line_done_o, 1'b0);
    tick(8);
    check("t4_no_req", req_cnt, 22);
    expect_line(24'h005100, 6, 1'b1);
    start_line(24'h005100, 11'd6);
    wait_done(5, 100);
    tick(3);
    check("t4_one_burst", req_cnt, 23);
    pop_words(4, 20);

    // Address wrap
    expect_line(24'hFFFFFC, 8, 1'b1);
    start_line(24'hFFFFFC, 11'd8);
    wait_done(6, 200);
    tick(2);
    check("t5_req", req_cnt, 25);
    check("t5_ack", ack_cnt, 25);
    pop_words(8, 40);

    // Underrun and asynchronous reset mid-burst
    exp_addr.push_back(24'h006000);
    start_line(24'h006000, 11'd8);
`ifdef VIDEO_LINE_FETCH_UNDERRUN_EN
    check("t6_underrun_clear", underrun_o, 1'b0);
    pix_rd_i = 1'b1;
    tick(1);
    pix_rd_i = 1'b0;
    check("t6_underrun_set", underrun_o, 1'b1);
`endif
    wait_data(20);
    check("t6_in_data", got_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rd", sdram_rd_o, 1'b0);
    check("t6_rst_ack", sdram_ack_o, 1'b0);
    check("t6_rst_busy", busy_o, 1'b0);
    check("t6_rst_done", line_done_o, 1'b0);
    check("t6_rst_empty", pix_empty_o, 1'b1);
`ifdef VIDEO_LINE_FETCH_UNDERRUN_EN
    check("t6_rst_underrun", underrun_o, 1'b0);
`endif
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("t6_idle_rd", sdram_rd_o, 1'b0);
    check("t6_idle_busy", busy_o, 1'b0);
    check("t6_addr_consumed", exp_addr.size(), 0);
    check("t6_pix_consumed", exp_pix.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
